// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and helpers for the PPU pixel pipeline
package ppu_pkg;

    localparam int LCD_WIDTH = 160;

    typedef enum logic [1:0] {IDLE, DISCARD, DRAW, DONE} mixer_state_t;

    // Two-bit shade for colour index idx within an 8-bit DMG palette
    function automatic logic [1:0] shade(input logic [7:0] pal, input logic [1:0] idx);
        return pal[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/palette_mux.sv
// palette_mux: BG/OBJ priority resolution and palette lookup for one pixel
module palette_mux import ppu_pkg::*; (
    input  logic [1:0] i_bg_pixel,
    input  logic       i_bg_ena,
    input  logic       i_obj_ena,
    input  logic       i_obj_valid,
    input  logic [1:0] i_obj_pixel,
    input  logic       i_obj_palette,
    input  logic       i_obj_priority,
    input  logic [7:0] i_bgp,
    input  logic [7:0] i_obp0,
    input  logic [7:0] i_obp1,
    output logic [1:0] o_shade
);

    logic [1:0] w_bc;
    logic       w_obj_win;

    // OBJ wins when visible, unless it sits behind a non-zero BG colour
    always_comb begin
        w_bc      = i_bg_ena ? i_bg_pixel : 2'd0;
        w_obj_win = i_obj_ena & i_obj_valid & (i_obj_pixel != 2'd0) & ~(i_obj_priority & (w_bc != 2'd0));
        o_shade   = w_obj_win ? shade(i_obj_palette ? i_obp1 : i_obp0, i_obj_pixel) : shade(i_bgp, w_bc);
    end

endmodule

// File: rtl/pixel_mixer.sv
// pixel_mixer: pops BG/OBJ FIFOs in lockstep, applies fine scroll and emits shaded pixels
module pixel_mixer import ppu_pkg::*; #(
    parameter int X_MAX = LCD_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tclk_in,
    input  logic                     line_start_in,
    input  logic [7:0]               SCX_in,
    input  logic                     bg_ena_in,
    input  logic                     obj_ena_in,
    input  logic [7:0]               BGP_in,
    input  logic [7:0]               OBP0_in,
    input  logic [7:0]               OBP1_in,
    input  logic                     sprite_hit_in,
    output logic                     bg_rd_en_out,
    input  logic [1:0]               bg_pixel_in,
    input  logic                     bg_valid_in,
    output logic                     obj_rd_en_out,
    input  logic [1:0]               obj_pixel_in,
    input  logic                     obj_palette_in,
    input  logic                     obj_priority_in,
    input  logic                     obj_valid_in,
    output logic [1:0]               pixel_out,
    output logic [$clog2(X_MAX)-1:0] X_out,
    output logic                     pixel_valid_out,
    output logic                     line_done_out
);

    localparam int XW = $clog2(X_MAX);

    mixer_state_t  r_state;
    logic [2:0]    r_fine;
    logic [XW-1:0] r_x_cnt;
    logic          r_drop;
    logic          w_valid;
    logic          w_emit;
    logic          w_last;
    logic [1:0]    w_shade;
    logic          w_unused_scx;

    // Pop requests, plus dropping of a pop that was issued on the clk a line was restarted
    always_comb begin
        bg_rd_en_out  = tclk_in & ~sprite_hit_in & (r_state == DISCARD || r_state == DRAW);
        obj_rd_en_out = bg_rd_en_out & (r_state == DRAW);
        w_valid       = bg_valid_in & ~r_drop;
        w_emit        = w_valid & ~line_start_in & (r_state == DRAW);
        w_last        = r_x_cnt == XW'(X_MAX - 1);
        w_unused_scx  = ^SCX_in[7:3];
    end

    palette_mux u_palette_mux (
        .i_bg_pixel     (bg_pixel_in),
        .i_bg_ena       (bg_ena_in),
        .i_obj_ena      (obj_ena_in),
        .i_obj_valid    (obj_valid_in),
        .i_obj_pixel    (obj_pixel_in),
        .i_obj_palette  (obj_palette_in),
        .i_obj_priority (obj_priority_in),
        .i_bgp          (BGP_in),
        .i_obp0         (OBP0_in),
        .i_obp1         (OBP1_in),
        .o_shade        (w_shade)
    );

    // Line FSM, fine-scroll discard counter, X counter and registered pixel outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state         <= IDLE;
            r_fine          <= 3'd0;
            r_x_cnt         <= '0;
            r_drop          <= 1'b0;
            pixel_out       <= 2'd0;
            X_out           <= '0;
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
        end else begin
            pixel_valid_out <= w_emit;
            line_done_out   <= w_emit & w_last;
            r_drop          <= line_start_in & bg_rd_en_out;
            if (w_emit) begin
                pixel_out <= w_shade;
                X_out     <= r_x_cnt;
            end
            if (line_start_in) begin
                r_state <= DISCARD;
                r_fine  <= SCX_in[2:0];
                r_x_cnt <= '0;
            end else begin
                case (r_state)
                    DISCARD: begin
                        if (w_valid && r_fine != 3'd0) r_fine <= r_fine - 3'd1;
                        if (r_fine == 3'd0 || (w_valid && r_fine == 3'd1)) r_state <= DRAW;
                    end
                    DRAW: if (w_emit) begin
                        if (w_last) r_state <= DONE;
                        else r_x_cnt <= r_x_cnt + 1'b1;
                    end
                    DONE:    r_state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule
